tdp_mem_port_arbiter: RTL
=========================

Name: tdp_mem_port_arbiter

Overview:
Shares one true dual-port memory (ports A/B, read-first, 1-cycle registered read) among NREQ requesters, e.g. feedforward read, backprop read and update write.
Grants at most two requests per cycle, one per port, with round-robin fairness.
Never issues a same-address pair where either access is a write.
Routes read data back to the issuing requester after the memory latency.

Parameters:
NREQ, 3, number of requesters (2..8)
depth, 8, memory cells
width, 4, bits per cell
MEM_LAT, 1, memory read latency in cycles (>=1)
addrsize (localparam), (depth==1)?1:$clog2(depth), address width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low; state reset when reset==0 at a clk edge
req_valid  in  [NREQ]  request present
req_ready  out  [NREQ]  grant this cycle (combinational); transfer = valid&&ready
req_we  in  [NREQ]  1=write, 0=read
req_addr  in  [NREQ][addrsize]  cell address
req_wdata  in  [NREQ][width]  write data
rsp_valid  out  [NREQ]  read data valid (registered)
rsp_rdata  out  [NREQ][width]  read data
weA, weB  out  1 each  memory write enables
addressA, addressB  out  addrsize each  memory addresses
data_inA, data_inB  out  width each  memory write data
data_outA, data_outB  in  width each  memory read data

Behaviour:
- Round-robin pointer ptr (0..NREQ-1), reset 0. Scan order ptr, ptr+1, ... mod NREQ.
- Port A gets the first valid requester in scan order.
- Port B gets the next valid requester, unless it conflicts with port A. Conflict = same address AND (either we=1).
  - A conflicting candidate is skipped, not granted, and scanning continues. Skipped requests stay pending; requesters hold valid/fields until ready.
- Two reads to the same address are both granted, one per port.
- Ungranted port: we=0, address=0, data_in=0. A granted read drives we=0 with data_in=0.
- ptr update: if any grant, ptr <= (index of last granted requester + 1) mod NREQ; otherwise ptr holds.
- Response pipeline, MEM_LAT stages per port: {valid, is_read, requester id}. Stage 0 is loaded with the grant.
  - At the final stage, a read routes data_outA/B to rsp_rdata[id] and pulses rsp_valid[id] for one cycle.
  - Writes produce no response.
  - Two ports completing for different ids in the same cycle are both delivered.
  - One requester can hold only one grant per cycle, so no id clash.
- Reset (reset==0): ptr=0, all pipeline valids cleared, rsp_valid=0, rsp_rdata=0. req_ready=0 and weA=weB=0 combinationally while reset==0.
- Reset mid-operation: in-flight reads are dropped, no response issued. Memory contents are not touched.
- Zero valid requests: no grants, ptr holds, memory ports idle.
- NREQ=2, both valid and in conflict: only the first in scan order is granted. The other is first next cycle, since ptr advances past the winner.

Optional Feature:
ARB_COLL_STATS_EN
- Defined: adds output coll_count [16] and input coll_clr [1].
  - coll_count increments (saturating at 16'hFFFF) each cycle in which at least one candidate is skipped for a conflict.
  - Cleared by reset or coll_clr=1; clear wins over increment.
- Undefined: no extra ports, no counter logic.

Decomposition:
- Package tdp_arb_pkg:
  - arb_req_t struct {we, addr, wdata} parameterised via localparams.
  - Port select enum PORT_A/PORT_B.
  - Function conflict(addr0, we0, addr1, we1).
- One sub-module, tdp_arb_rsp_pipe: the MEM_LAT-deep id/valid shift register for one port, instantiated twice.

Test Plan:
- NREQ=3, only req1 valid, read addr 2 holding 4'h9 -> req_ready=3'b010, addressA=2, weA=0; next cycle rsp_valid[1]=1, rsp_rdata[1]=4'h9; ptr=2.
- req0 write addr 3 data 4'h5, req1 read addr 3, ptr=0 -> only req0 granted on port A, port B idle. Next cycle req1 granted on A, returns 4'h5 one cycle later.
- req0 read addr 1, req1 read addr 1, req2 write addr 4 data 4'hc, ptr=0 -> req0 on A, req1 on B; req2 waits. Next cycle req2 granted on A; both reads return mem[1].
- All three valid continuously, distinct addresses, 6 cycles -> grant pairs cycle (0,1),(2,0),(1,2),...; each requester granted exactly 4 times.
- reset driven 0 in the cycle after a read grant -> no rsp_valid pulses afterwards, req_ready=0 during reset, ptr=0 after release.
- ARB_COLL_STATS_EN: 3 consecutive conflict cycles then coll_clr=1 -> coll_count reads 1,2,3 then 0.

Source files
------------

// File: rtl/tdp_arb_pkg.sv
// Shared types and helpers for the true-dual-port memory arbiter.
package tdp_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 16;
  localparam int unsigned ARB_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // Same cell with at least one write cannot share a cycle across the two ports.
  function automatic logic conflict(input logic [ARB_ADDR_W-1:0] addr0, input logic we0,
                                    input logic [ARB_ADDR_W-1:0] addr1, input logic we1);
    return (addr0 == addr1) && (we0 || we1);
  endfunction

endpackage

// File: rtl/tdp_arb_rsp_pipe.sv
// MEM_LAT-deep {valid, is_read, id} shift register tracking one memory port.
module tdp_arb_rsp_pipe #(
  parameter int MEM_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           in_is_read,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  output logic           out_is_read,
  output logic [IDW-1:0] out_id
);

  logic [MEM_LAT-1:0]          v;
  logic [MEM_LAT-1:0]          rd;
  logic [MEM_LAT-1:0][IDW-1:0] id;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v  <= '0;
      rd <= '0;
      id <= '0;
    end else begin
      v[0]  <= in_valid;
      rd[0] <= in_is_read;
      id[0] <= in_id;
      for (int unsigned s = 1; s < MEM_LAT; s++) begin
        v[s]  <= v[s-1];
        rd[s] <= rd[s-1];
        id[s] <= id[s-1];
      end
    end
  end

  assign out_valid   = v[MEM_LAT-1];
  assign out_is_read = rd[MEM_LAT-1];
  assign out_id      = id[MEM_LAT-1];

endmodule

// File: rtl/tdp_mem_port_arbiter.sv
// Round-robin arbiter sharing a read-first true-dual-port memory among NREQ requesters.
// Optional conflict statistics counter enabled by defining ARB_COLL_STATS_EN.
module tdp_mem_port_arbiter
  import tdp_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int depth   = 8,
  parameter int width   = 4,
  parameter int MEM_LAT = 1,
  localparam int addrsize = (depth == 1) ? 1 : $clog2(depth)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ-1:0][addrsize-1:0]  req_addr,
  input  logic [NREQ-1:0][width-1:0]     req_wdata,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [NREQ-1:0][width-1:0]     rsp_rdata,
  output logic                           weA,
  output logic                           weB,
  output logic [addrsize-1:0]            addressA,
  output logic [addrsize-1:0]            addressB,
  output logic [width-1:0]               data_inA,
  output logic [width-1:0]               data_inB,
  input  logic [width-1:0]               data_outA,
  input  logic [width-1:0]               data_outB
`ifdef ARB_COLL_STATS_EN
  ,
  output logic [15:0]                    coll_count,
  input  logic                           coll_clr
`endif
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic           gnt_a, gnt_b;
  logic [IDW-1:0] id_a, id_b;
`ifdef ARB_COLL_STATS_EN
  logic           skip;
`endif

  // Single pass in round-robin order: A takes the first valid, B the next non-conflicting one.
  always_comb begin
    idx   = '0;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    id_a  = '0;
    id_b  = '0;
`ifdef ARB_COLL_STATS_EN
    skip  = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (reset && req_valid[idx]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          id_a  = idx;
        end else if (!gnt_b) begin
          if (conflict(ARB_ADDR_W'(req_addr[id_a]), req_we[id_a],
                       ARB_ADDR_W'(req_addr[idx]), req_we[idx])) begin
`ifdef ARB_COLL_STATS_EN
            skip = 1'b1;
`endif
          end else begin
            gnt_b = 1'b1;
            id_b  = idx;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[id_a] = 1'b1;
    if (gnt_b) req_ready[id_b] = 1'b1;
    weA      = gnt_a && req_we[id_a];
    weB      = gnt_b && req_we[id_b];
    addressA = gnt_a ? req_addr[id_a] : '0;
    addressB = gnt_b ? req_addr[id_b] : '0;
    data_inA = weA ? req_wdata[id_a] : '0;
    data_inB = weB ? req_wdata[id_b] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gnt_a) begin
      ptr <= IDW'((32'(gnt_b ? id_b : id_a) + 32'd1) % NREQ);
    end
  end

  logic           pv  [2];
  logic           prd [2];
  logic [IDW-1:0] pid [2];

  tdp_arb_rsp_pipe #(.MEM_LAT(MEM_LAT), .IDW(IDW)) u_pipe_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (gnt_a),
    .in_is_read (gnt_a && !req_we[id_a]),
    .in_id      (id_a),
    .out_valid  (pv[PORT_A]),
    .out_is_read(prd[PORT_A]),
    .out_id     (pid[PORT_A])
  );

  tdp_arb_rsp_pipe #(.MEM_LAT(MEM_LAT), .IDW(IDW)) u_pipe_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (gnt_b),
    .in_is_read (gnt_b && !req_we[id_b]),
    .in_id      (id_b),
    .out_valid  (pv[PORT_B]),
    .out_is_read(prd[PORT_B]),
    .out_id     (pid[PORT_B])
  );

  // Pipeline flops are the registered source; gating by reset drops in-flight reads immediately.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (reset) begin
      if (pv[PORT_A] && prd[PORT_A]) begin
        rsp_valid[pid[PORT_A]] = 1'b1;
        rsp_rdata[pid[PORT_A]] = data_outA;
      end
      if (pv[PORT_B] && prd[PORT_B]) begin
        rsp_valid[pid[PORT_B]] = 1'b1;
        rsp_rdata[pid[PORT_B]] = data_outB;
      end
    end
  end

`ifdef ARB_COLL_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset || coll_clr) begin
      coll_count <= '0;
    end else if (skip && (coll_count != 16'hFFFF)) begin
      coll_count <= coll_count + 16'd1;
    end
  end
`endif

endmodule
